// File: rtl/jstk_pkg.sv
// rtl/jstk_pkg.sv - shared types and constants for the PmodJSTK master and slave blocks
// Contents: state encoding, LED command opcode, default frame length in bytes.
package jstk_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } jstkState_t;

   // Byte 0 of a command frame with this upper 6-bit opcode carries LED bits in [1:0].
   localparam logic [5:0] LED_CMD_OP = 6'b100000;

   localparam int DEFAULT_BYTES = 5;

endpackage

// File: rtl/jstk_sync_edge.sv
// rtl/jstk_sync_edge.sv - multi-stage pin synchronizer with registered rise/fall strobes
// Ports:
//   CLK, RST  system clock, asynchronous active-high reset
//   pin       asynchronous input pin
//   syncOut   synchronized level (STAGES cycles behind pin)
//   rise/fall one-cycle strobes, STAGES+1 cycles behind the pin edge
module jstk_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic CLK,
   input  logic RST,
   input  logic pin,
   output logic syncOut,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic [STAGES:0]   warm;
   logic              prev;

   // The warm-up chain holds the strobes off until both the synchronized level and
   // the edge register carry real pin samples. Without it, a pin sitting at the
   // opposite of RESET_VAL when reset releases would fake an edge.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         chain <= {STAGES{RESET_VAL}};
         warm  <= '0;
         prev  <= RESET_VAL;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], pin};
         warm  <= {warm[STAGES-1:0], 1'b1};
         prev  <= chain[STAGES-1];
         rise  <= warm[STAGES] &  chain[STAGES-1] & ~prev;
         fall  <= warm[STAGES] & ~chain[STAGES-1] &  prev;
      end
   end

   assign syncOut = chain[STAGES-1];

endmodule

// File: rtl/jstk_spi_slave.sv
// rtl/jstk_spi_slave.sv - SPI mode-0 responder emulating the PmodJSTK 5-byte frame protocol
// Ports:
//   CLK, RST         system clock, asynchronous active-high reset
//   SCLK, MOSI, SS   asynchronous SPI pins from the master (SS active low)
//   MISO, MISO_OE    serial response and pad enable
//   TXDATA           response frame, byte 0 in the top byte, sampled at SS fall
//   RXDATA, RXVALID  last good command frame and its one-cycle update pulse
//   FRAMEERR         one-cycle pulse for a short or overlong frame
//   BUSY             high while a frame is active
//   LED              LED command state, only with JSTK_SLV_LEDCMD_EN defined
module jstk_spi_slave
   import jstk_pkg::*;
#(
   parameter int BYTES       = DEFAULT_BYTES,
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              SCLK,
   input  logic              MOSI,
   input  logic              SS,
   output logic              MISO,
   output logic              MISO_OE,
   input  logic [8*BYTES-1:0] TXDATA,
   output logic [8*BYTES-1:0] RXDATA,
   output logic              RXVALID,
   output logic              FRAMEERR,
   output logic              BUSY
`ifdef JSTK_SLV_LEDCMD_EN
   ,
   output logic [1:0]        LED
`endif
);

   localparam int FW = 8 * BYTES;
   localparam logic [6:0] CNT_FULL = 7'(FW);
   localparam logic [6:0] CNT_OVR  = 7'(FW + 1);

   logic ssSync, ssRise, ssFall;
   logic sclkSync, sclkRise, sclkFall;
   logic mosiSync, mosiRise, mosiFall;
   logic unusedSync;

   jstk_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) ssSyncInst (
      .CLK(CLK), .RST(RST), .pin(SS),
      .syncOut(ssSync), .rise(ssRise), .fall(ssFall)
   );

   jstk_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) sclkSyncInst (
      .CLK(CLK), .RST(RST), .pin(SCLK),
      .syncOut(sclkSync), .rise(sclkRise), .fall(sclkFall)
   );

   jstk_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) mosiSyncInst (
      .CLK(CLK), .RST(RST), .pin(MOSI),
      .syncOut(mosiSync), .rise(mosiRise), .fall(mosiFall)
   );

   // Only the strobes of SS/SCLK and the level of MOSI are consumed.
   assign unusedSync = ^{ssSync, sclkSync, mosiRise, mosiFall};

   jstkState_t state, nextState;
   logic [FW-1:0] txShift;
   logic [FW-1:0] rxShift;
   logic [6:0]    bitCnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:   if (ssFall) nextState = ACTIVE;
         ACTIVE: if (ssRise) nextState = IDLE;
      endcase
   end

   // SS strobes take priority: an SCLK strobe landing in the same cycle as an SS
   // edge is dropped.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         txShift  <= '0;
         rxShift  <= '0;
         bitCnt   <= '0;
         RXDATA   <= '0;
         RXVALID  <= 1'b0;
         FRAMEERR <= 1'b0;
`ifdef JSTK_SLV_LEDCMD_EN
         LED      <= 2'b00;
`endif
      end else begin
         RXVALID  <= 1'b0;
         FRAMEERR <= 1'b0;
         case (state)
            IDLE: begin
               if (ssFall) begin
                  txShift <= TXDATA;
                  rxShift <= '0;
                  bitCnt  <= '0;
               end
            end
            ACTIVE: begin
               if (ssRise) begin
                  if (bitCnt == CNT_FULL) begin
                     RXDATA  <= rxShift;
                     RXVALID <= 1'b1;
`ifdef JSTK_SLV_LEDCMD_EN
                     if (rxShift[FW-1:FW-6] == LED_CMD_OP) begin
                        LED <= rxShift[FW-7:FW-8];
                     end
`endif
                  end else begin
                     FRAMEERR <= 1'b1;
                  end
               end else begin
                  if (sclkRise) begin
                     rxShift <= {rxShift[FW-2:0], mosiSync};
                     // Saturating at FW+1 keeps any overrun distinguishable from a full frame.
                     if (bitCnt != CNT_OVR) begin
                        bitCnt <= bitCnt + 7'd1;
                     end
                  end
                  if (sclkFall) begin
                     txShift <= {txShift[FW-2:0], 1'b0};
                  end
               end
            end
         endcase
      end
   end

   // Zero fill on shifting means an overrun master clocks in zeros past the frame.
   assign MISO    = txShift[FW-1];
   assign BUSY    = (state == ACTIVE);
   assign MISO_OE = (state == ACTIVE);

endmodule

// File: tb/tb_jstk_spi_slave.sv
// tb/tb_jstk_spi_slave.sv - self-checking bench for jstk_spi_slave with an SPI master model at CLK/16
module tb_jstk_spi_slave;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        SCLK = 1'b0;
   logic        MOSI = 1'b0;
   logic        SS = 1'b1;
   logic [39:0] TXDATA = '0;
   logic        MISO, MISO_OE, RXVALID, FRAMEERR, BUSY;
   logic [39:0] RXDATA;
`ifdef JSTK_SLV_LEDCMD_EN
   logic [1:0]  LED;
`endif

   jstk_spi_slave #(.BYTES(5), .SYNC_STAGES(2)) dut (
      .CLK(CLK), .RST(RST), .SCLK(SCLK), .MOSI(MOSI), .SS(SS),
      .MISO(MISO), .MISO_OE(MISO_OE), .TXDATA(TXDATA), .RXDATA(RXDATA),
      .RXVALID(RXVALID), .FRAMEERR(FRAMEERR), .BUSY(BUSY)
`ifdef JSTK_SLV_LEDCMD_EN
      , .LED(LED)
`endif
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad = 0;
   int rxvCount = 0;
   int ferrCount = 0;
   logic activeDrop;
   logic activeSeen;

   logic [39:0] expMiso[$];
   logic [39:0] expRx[$];

   always @(negedge CLK) begin
      if (RXVALID === 1'b1) rxvCount = rxvCount + 1;
      if (FRAMEERR === 1'b1) ferrCount = ferrCount + 1;
   end

   // One SCLK period: low half then high half, MISO sampled just after the rise.
   task automatic sclkBit(input logic b, output logic misoBit);
      MOSI = b;
      repeat (8) @(posedge CLK);
      SCLK = 1'b1;
      @(negedge CLK);
      misoBit = MISO;
      if (MISO_OE !== 1'b1 || BUSY !== 1'b1) activeDrop = 1'b1;
      if (MISO_OE === 1'b1 || BUSY === 1'b1) activeSeen = 1'b1;
      repeat (8) @(posedge CLK);
      SCLK = 1'b0;
   endtask

   task automatic spiFrame(input logic [39:0] mosiWord, input int nbits, input bit changeTx,
                           output logic [39:0] misoWord, output logic extraBit);
      logic mb;
      misoWord = '0;
      extraBit = 1'b0;
      activeDrop = 1'b0;
      @(posedge CLK);
      SS = 1'b0;
      repeat (8) @(posedge CLK);
      for (int i = 0; i < nbits; i++) begin
         sclkBit((i < 40) ? mosiWord[39-i] : 1'b1, mb);
         if (i < 40) misoWord = {misoWord[38:0], mb};
         else extraBit = mb;
         if (changeTx && i == 20) TXDATA = '1;
      end
      repeat (8) @(posedge CLK);
      SS = 1'b1;
      repeat (12) @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic test_reset;
      repeat (4) @(posedge CLK);
      RST = 1'b0;
      repeat (6) @(posedge CLK);
      @(negedge CLK);
      total++; if (MISO !== 1'b0) begin bad++; $display("FAIL reset_miso: got %b want 0", MISO); end
      total++; if (MISO_OE !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", MISO_OE); end
      total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
      total++; if (RXDATA !== 40'h0) begin bad++; $display("FAIL reset_rxdata: got %h want 0", RXDATA); end
      total++; if (rxvCount !== 0 || ferrCount !== 0) begin
         bad++; $display("FAIL reset_pulses: got rxv=%0d ferr=%0d want 0 0", rxvCount, ferrCount);
      end
`ifdef JSTK_SLV_LEDCMD_EN
      total++; if (LED !== 2'b00) begin bad++; $display("FAIL reset_led: got %b want 00", LED); end
`endif
   endtask

   task automatic test_good_frame;
      logic [39:0] miso, e;
      logic extra;
      int rv0, fe0;
      TXDATA = 40'hA1B2C3D4E5;
      expMiso.push_back(40'hA1B2C3D4E5);
      expRx.push_back(40'h8300000000);
      rv0 = rxvCount; fe0 = ferrCount;
      spiFrame(40'h8300000000, 40, 1'b0, miso, extra);
      e = expMiso.pop_front();
      total++; if (miso !== e) begin bad++; $display("FAIL good_miso: got %h want %h", miso, e); end
      total++; if (rxvCount - rv0 !== 1) begin bad++; $display("FAIL good_rxvalid: got %0d pulses want 1", rxvCount - rv0); end
      total++; if (ferrCount - fe0 !== 0) begin bad++; $display("FAIL good_frameerr: got %0d pulses want 0", ferrCount - fe0); end
      e = expRx.pop_front();
      total++; if (RXDATA !== e) begin bad++; $display("FAIL good_rxdata: got %h want %h", RXDATA, e); end
      total++; if (activeDrop !== 1'b0) begin bad++; $display("FAIL good_active: got drop=%b want 0", activeDrop); end
      total++; if (BUSY !== 1'b0 || MISO_OE !== 1'b0) begin
         bad++; $display("FAIL good_idle_after: got busy=%b oe=%b want 0 0", BUSY, MISO_OE);
      end
`ifdef JSTK_SLV_LEDCMD_EN
      total++; if (LED !== 2'b11) begin bad++; $display("FAIL good_led: got %b want 11", LED); end
`endif
   endtask

   task automatic test_short_frame;
      logic [39:0] miso;
      logic extra;
      int rv0, fe0;
      TXDATA = 40'h5555555555;
      rv0 = rxvCount; fe0 = ferrCount;
      spiFrame(40'h123456789A, 36, 1'b0, miso, extra);
      total++; if (ferrCount - fe0 !== 1) begin bad++; $display("FAIL short_frameerr: got %0d pulses want 1", ferrCount - fe0); end
      total++; if (rxvCount - rv0 !== 0) begin bad++; $display("FAIL short_rxvalid: got %0d pulses want 0", rxvCount - rv0); end
      total++; if (RXDATA !== 40'h8300000000) begin bad++; $display("FAIL short_rxdata: got %h want 8300000000", RXDATA); end
   endtask

   task automatic test_overlong;
      logic [39:0] miso, e;
      logic extra;
      int rv0, fe0;
      TXDATA = 40'h5A5A5A5A5A;
      expMiso.push_back(40'h5A5A5A5A5A);
      rv0 = rxvCount; fe0 = ferrCount;
      spiFrame(40'hFFFFFFFFFF, 41, 1'b0, miso, extra);
      e = expMiso.pop_front();
      total++; if (miso !== e) begin bad++; $display("FAIL long_miso: got %h want %h", miso, e); end
      total++; if (extra !== 1'b0) begin bad++; $display("FAIL long_bit41: got %b want 0", extra); end
      total++; if (ferrCount - fe0 !== 1) begin bad++; $display("FAIL long_frameerr: got %0d pulses want 1", ferrCount - fe0); end
      total++; if (rxvCount - rv0 !== 0) begin bad++; $display("FAIL long_rxvalid: got %0d pulses want 0", rxvCount - rv0); end
      total++; if (RXDATA !== 40'h8300000000) begin bad++; $display("FAIL long_rxdata: got %h want 8300000000", RXDATA); end
   endtask

   task automatic test_tx_change;
      logic [39:0] miso, e;
      logic extra;
      int rv0;
      TXDATA = 40'hA1B2C3D4E5;
      expMiso.push_back(40'hA1B2C3D4E5);
      expRx.push_back(40'h0123456789);
      rv0 = rxvCount;
      spiFrame(40'h0123456789, 40, 1'b1, miso, extra);
      e = expMiso.pop_front();
      total++; if (miso !== e) begin bad++; $display("FAIL txchg_miso: got %h want %h", miso, e); end
      total++; if (rxvCount - rv0 !== 1) begin bad++; $display("FAIL txchg_rxvalid: got %0d pulses want 1", rxvCount - rv0); end
      e = expRx.pop_front();
      total++; if (RXDATA !== e) begin bad++; $display("FAIL txchg_rxdata: got %h want %h", RXDATA, e); end
`ifdef JSTK_SLV_LEDCMD_EN
      total++; if (LED !== 2'b11) begin bad++; $display("FAIL txchg_led_kept: got %b want 11", LED); end
`endif
   endtask

   task automatic test_ss_high_sclk;
      logic mb;
      int rv0, fe0;
      rv0 = rxvCount; fe0 = ferrCount;
      activeSeen = 1'b0;
      for (int i = 0; i < 16; i++) sclkBit(i[0], mb);
      repeat (12) @(posedge CLK);
      @(negedge CLK);
      total++; if (activeSeen !== 1'b0) begin bad++; $display("FAIL sshigh_active: got %b want 0", activeSeen); end
      total++; if (rxvCount - rv0 !== 0 || ferrCount - fe0 !== 0) begin
         bad++; $display("FAIL sshigh_pulses: got rxv=%0d ferr=%0d want 0 0", rxvCount - rv0, ferrCount - fe0);
      end
      total++; if (RXDATA !== 40'h0123456789) begin bad++; $display("FAIL sshigh_rxdata: got %h want 0123456789", RXDATA); end
   endtask

   task automatic test_reset_midframe;
      logic [39:0] miso, e;
      logic extra, mb;
      int rv0, fe0;
      TXDATA = 40'hA1B2C3D4E5;
      @(posedge CLK);
      SS = 1'b0;
      repeat (8) @(posedge CLK);
      for (int i = 0; i < 20; i++) sclkBit(1'b1, mb);
      repeat (2) @(posedge CLK);
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      RST = 1'b0;
      repeat (10) @(posedge CLK);
      @(negedge CLK);
      total++; if (RXDATA !== 40'h0) begin bad++; $display("FAIL rstmid_rxdata: got %h want 0", RXDATA); end
      total++; if (BUSY !== 1'b0 || MISO_OE !== 1'b0 || MISO !== 1'b0) begin
         bad++; $display("FAIL rstmid_outputs: got busy=%b oe=%b miso=%b want 0 0 0", BUSY, MISO_OE, MISO);
      end
`ifdef JSTK_SLV_LEDCMD_EN
      total++; if (LED !== 2'b00) begin bad++; $display("FAIL rstmid_led: got %b want 00", LED); end
`endif
      rv0 = rxvCount; fe0 = ferrCount;
      activeSeen = 1'b0;
      for (int i = 0; i < 4; i++) sclkBit(1'b1, mb);
      SS = 1'b1;
      repeat (12) @(posedge CLK);
      @(negedge CLK);
      total++; if (activeSeen !== 1'b0) begin bad++; $display("FAIL rstmid_stays_idle: got %b want 0", activeSeen); end
      total++; if (rxvCount - rv0 !== 0 || ferrCount - fe0 !== 0) begin
         bad++; $display("FAIL rstmid_pulses: got rxv=%0d ferr=%0d want 0 0", rxvCount - rv0, ferrCount - fe0);
      end
      expMiso.push_back(40'hA1B2C3D4E5);
      expRx.push_back(40'h8100000000);
      rv0 = rxvCount;
      spiFrame(40'h8100000000, 40, 1'b0, miso, extra);
      e = expMiso.pop_front();
      total++; if (miso !== e) begin bad++; $display("FAIL rstmid_next_miso: got %h want %h", miso, e); end
      total++; if (rxvCount - rv0 !== 1) begin bad++; $display("FAIL rstmid_next_rxvalid: got %0d pulses want 1", rxvCount - rv0); end
      e = expRx.pop_front();
      total++; if (RXDATA !== e) begin bad++; $display("FAIL rstmid_next_rxdata: got %h want %h", RXDATA, e); end
`ifdef JSTK_SLV_LEDCMD_EN
      total++; if (LED !== 2'b01) begin bad++; $display("FAIL rstmid_next_led: got %b want 01", LED); end
`endif
   endtask

   initial begin
      activeDrop = 1'b0;
      activeSeen = 1'b0;
      test_reset();
      test_good_frame();
      test_short_frame();
      test_overlong();
      test_tx_change();
      test_ss_high_sclk();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
